// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline constants and instruction field positions
package pipe_pkg;
  localparam int INSTR_W = 32;
  localparam int REG_W = 5;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RSRT_W = RS_MSB - RT_LSB + 1;
  localparam logic [INSTR_W-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;
endpackage

// File: rtl/if_id_stage_if.sv
// if_id_stage_if: fetch/decode bus linking IF/ID with imem, ID and ID_EX
interface if_id_stage_if #(parameter int CNT_W = 16);
  import pipe_pkg::*;
  logic [INSTR_W-1:0] instr;
  logic pcsrc;
  logic [INSTR_W-1:0] branch_target;
  logic mem_read_ex;
  logic [REG_W-1:0] rt_ex;
  logic [INSTR_W-1:0] pc;
  logic [INSTR_W-1:0] instr_id;
  logic [INSTR_W-1:0] pcplus4_id;
  logic valid_id;
  logic stall;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  modport master (
    input instr, pcsrc, branch_target, mem_read_ex, rt_ex,
    output pc, instr_id, pcplus4_id, valid_id, stall, stall_count, flush_count
  );
  modport slave (
    output instr, pcsrc, branch_target, mem_read_ex, rt_ex,
    input pc, instr_id, pcplus4_id, valid_id, stall, stall_count, flush_count
  );
endinterface

// File: rtl/load_use_hazard.sv
// load_use_hazard: flags a decode instruction reading the register an EX-stage load writes
module load_use_hazard
  import pipe_pkg::*;
(
  input  logic              valid_id_i,
  input  logic              mem_read_ex_i,
  input  logic [REG_W-1:0]  rt_ex_i,
  input  logic [RSRT_W-1:0] rs_rt_i,
  output logic              stall_o
);
  logic [REG_W-1:0] rs, rt;
  assign rs = rs_rt_i[RS_MSB-RT_LSB -: REG_W];
  assign rt = rs_rt_i[RT_MSB-RT_LSB -: REG_W];
  // rt compared regardless of opcode; $zero is never a hazard
  assign stall_o = valid_id_i && mem_read_ex_i && rt_ex_i != '0 && (rt_ex_i == rs || rt_ex_i == rt);
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: PC register, IF/ID pipeline register, load-use stall and branch squash
module if_id_stage
  import pipe_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  if_id_stage_if.master bus
);
  logic [INSTR_W-1:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d, pc_plus4;
  logic valid_q, valid_d, stall;
  logic [CNT_W-1:0] scnt_q, scnt_d, fcnt_q, fcnt_d;
  load_use_hazard u_hazard (
    .valid_id_i   (valid_q),
    .mem_read_ex_i(bus.mem_read_ex),
    .rt_ex_i      (bus.rt_ex),
    .rs_rt_i      (instr_q[RS_MSB:RT_LSB]),
    .stall_o      (stall)
  );
  // a stall freezes everything, including a branch whose operands are stale
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    pc_d = stall ? pc_q : bus.pcsrc ? {bus.branch_target[INSTR_W-1:2], 2'b00} : pc_plus4;
    instr_d = stall ? instr_q : bus.pcsrc ? NOP_INSTR : bus.instr;
    pc4_d = stall ? pc4_q : bus.pcsrc ? '0 : pc_plus4;
    valid_d = stall ? valid_q : !bus.pcsrc;
    scnt_d = scnt_q + CNT_W'(stall && !(&scnt_q));
    fcnt_d = fcnt_q + CNT_W'(!stall && bus.pcsrc && !(&fcnt_q));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q <= '0;
      valid_q <= 1'b0;
      scnt_q <= '0;
      fcnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      instr_q <= instr_d;
      pc4_q <= pc4_d;
      valid_q <= valid_d;
      scnt_q <= scnt_d;
      fcnt_q <= fcnt_d;
    end
  end
  assign bus.pc = pc_q;
  assign bus.instr_id = instr_q;
  assign bus.pcplus4_id = pc4_q;
  assign bus.valid_id = valid_q;
  assign bus.stall = stall;
  assign bus.stall_count = scnt_q;
  assign bus.flush_count = fcnt_q;
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: random stimulus, reference model and scoreboard for two stage instances
module tb_if_id_stage;
  import pipe_pkg::*;
  localparam logic [31:0] RPC_B = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP = 32'h0000_0000;
  typedef struct {
    logic [31:0] pc, instr, pc4;
    logic valid;
    int scnt, fcnt;
  } ms_t;
  typedef struct {
    ms_t a, b;
    logic sa, sb;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pcsrc = 1'b0;
  logic mr = 1'b0;
  logic [31:0] tgt = '0;
  logic [4:0] rt = '0;
  logic [31:0] mem [64];
  exp_t q[$];
  ms_t sa, sb;
  int total = 0;
  int bad = 0;
  if_id_stage_if #(.CNT_W(16)) ba();
  if_id_stage_if #(.CNT_W(2)) bb();
  if_id_stage #(.CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ba));
  if_id_stage #(.RESET_PC(RPC_B), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bb));
  assign ba.instr = mem[ba.pc[7:2]];
  assign bb.instr = mem[bb.pc[7:2]];
  assign ba.pcsrc = pcsrc;
  assign bb.pcsrc = pcsrc;
  assign ba.branch_target = tgt;
  assign bb.branch_target = tgt;
  assign ba.mem_read_ex = mr;
  assign bb.mem_read_ex = mr;
  assign ba.rt_ex = rt;
  assign bb.rt_ex = rt;
  always #5 clk = ~clk;
  function automatic ms_t rst_state(logic [31:0] rpc);
    ms_t s;
    s.pc = rpc;
    s.instr = NOP;
    s.pc4 = '0;
    s.valid = 1'b0;
    s.scnt = 0;
    s.fcnt = 0;
    return s;
  endfunction
  function automatic logic haz(ms_t s);
    return s.valid && mr && rt != 0 && (rt == s.instr[25:21] || rt == s.instr[20:16]);
  endfunction
  function automatic ms_t step(ms_t s, int cmax);
    ms_t n = s;
    if (haz(s)) n.scnt = (s.scnt < cmax) ? s.scnt + 1 : cmax;
    else if (pcsrc) begin
      n.pc = tgt & ~32'h3;
      n.instr = NOP;
      n.pc4 = '0;
      n.valid = 1'b0;
      n.fcnt = (s.fcnt < cmax) ? s.fcnt + 1 : cmax;
    end else begin
      n.instr = mem[s.pc[7:2]];
      n.pc = s.pc + 32'd4;
      n.pc4 = s.pc + 32'd4;
      n.valid = 1'b1;
    end
    return n;
  endfunction
  task automatic push;
    exp_t e;
    e.a = sa;
    e.b = sb;
    e.sa = haz(sa);
    e.sb = haz(sb);
    q.push_back(e);
  endtask
  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("a_pc", ba.pc, e.a.pc);
      chk("a_instr_id", ba.instr_id, e.a.instr);
      chk("a_pcplus4_id", ba.pcplus4_id, e.a.pc4);
      chk("a_valid_id", 32'(ba.valid_id), 32'(e.a.valid));
      chk("a_stall", 32'(ba.stall), 32'(e.sa));
      chk("a_stall_count", 32'(ba.stall_count), 32'(e.a.scnt));
      chk("a_flush_count", 32'(ba.flush_count), 32'(e.a.fcnt));
      chk("b_pc", bb.pc, e.b.pc);
      chk("b_instr_id", bb.instr_id, e.b.instr);
      chk("b_pcplus4_id", bb.pcplus4_id, e.b.pc4);
      chk("b_valid_id", 32'(bb.valid_id), 32'(e.b.valid));
      chk("b_stall", 32'(bb.stall), 32'(e.sb));
      chk("b_stall_count", 32'(bb.stall_count), 32'(e.b.scnt));
      chk("b_flush_count", 32'(bb.flush_count), 32'(e.b.fcnt));
    end
  end
  initial begin
    int w;
    for (int i = 0; i < 64; i++)
      mem[i] = {6'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
    mem[1] = 32'h0045_1820;
    sa = rst_state(RESET_PC_DEF);
    sb = rst_state(RPC_B);
    repeat (2) @(posedge clk);
    #1 push();
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      int k;
      @(posedge clk);
      #1;
      sa = step(sa, 65535);
      sb = step(sb, 3);
      pcsrc = $urandom_range(0, 3) == 0;
      mr = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 9);
      rt = k == 0 ? sa.instr[25:21] : k == 1 ? sa.instr[20:16] :
           k == 2 ? sb.instr[25:21] : k == 3 ? sb.instr[20:16] : 5'($urandom_range(0, 7));
      tgt = $urandom_range(0, 15) == 0 ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7))) : 32'($urandom_range(0, 255));
      if ((haz(sa) || haz(sb)) && $urandom_range(0, 7) == 0) begin
        rst_n = 1'b0;
        #1;
        sa = rst_state(RESET_PC_DEF);
        sb = rst_state(RPC_B);
        rst_n = 1'b1;
      end
      push();
    end
    w = 0;
    while (q.size() != 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
